// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Definitions shared by banco_registradores, the ULA and mult_sequencial.
//
//   LARGURA_DADO : datapath width of the CPU (register file words, ULA operands)
//   estado_t     : state encoding of the sequential multiplier FSM
//                  OCIOSO = idle, CALC = one partial product per clock,
//                  FIM = publish the product and pulse pronto
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned LARGURA_DADO = 16;

  // Binary encoded; values are fixed so other stages and debug views can decode them.
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } estado_t;

  // Width of the iteration counter for a LARGURA-bit multiplier.
  function automatic int unsigned largura_cont(input int unsigned largura);
    return $clog2(largura) + 1;
  endfunction

endpackage

// File: rtl/mult_sequencial.sv
// -----------------------------------------------------------------------------
// mult_sequencial
//   Radix-2 unsigned shift-add multiplier for the ULA. One partial product is
//   accumulated per clock; the full 2*LARGURA-bit product is published in
//   resultado together with a one-cycle pronto pulse.
//
//   Ports
//     clk        in   stage clock, all flops on posedge
//     reset_n    in   asynchronous active-low reset
//     ini        in   start request (level); only its rising edge starts an operation
//     A          in   multiplicand, unsigned, sampled at start
//     B          in   multiplier, unsigned, sampled at start
//     resultado  out  registered product, held until the next completion
//     ocupado    out  high while an operation is in progress
//     pronto     out  one-cycle pulse when resultado is updated
//
//   Timing (LARGURA=16): start edge k, CALC edges k+1..k+16, resultado/pronto
//   after edge k+17, next start accepted at edge k+18.
// -----------------------------------------------------------------------------
module mult_sequencial
  import cpu_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_DADO
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ini,
  input  logic [LARGURA-1:0]     A,
  input  logic [LARGURA-1:0]     B,
  output logic [2*LARGURA-1:0]   resultado,
  output logic                   ocupado,
  output logic                   pronto
);

  localparam int unsigned LargCont = largura_cont(LARGURA);
  localparam logic [LargCont-1:0] UltimoPasso = LargCont'(LARGURA - 1);

  estado_t               estado;
  logic                  ini_q;
  logic [LARGURA-1:0]    m;      // latched multiplicand
  logic [2*LARGURA-1:0]  p;      // {accumulator, remaining multiplier bits}
  logic [LargCont-1:0]   cont;

  logic                  inicio;
  logic [LARGURA-1:0]    parcela;
  logic [LARGURA:0]      soma;   // one extra bit keeps the carry of the add

  // ini_q follows ini every cycle, so a held-high ini yields a single start.
  assign inicio = ini & ~ini_q;

  always_comb begin
    parcela = p[0] ? m : '0;
    soma    = {1'b0, p[2*LARGURA-1:LARGURA]} + {1'b0, parcela};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= OCIOSO;
      ini_q     <= 1'b0;
      m         <= '0;
      p         <= '0;
      cont      <= '0;
      resultado <= '0;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
    end else begin
      ini_q  <= ini;
      pronto <= 1'b0;

      unique case (estado)
        OCIOSO: begin
          if (inicio) begin
            m       <= A;
            p       <= {{LARGURA{1'b0}}, B};
            cont    <= '0;
            ocupado <= 1'b1;
            estado  <= CALC;
          end
        end

        CALC: begin
          // Shift right with the add carry entering the MSB.
          p    <= {soma, p[LARGURA-1:1]};
          cont <= cont + 1'b1;
          if (cont == UltimoPasso) begin
            estado <= FIM;
          end
        end

        FIM: begin
          resultado <= p;
          pronto    <= 1'b1;
          ocupado   <= 1'b0;
          estado    <= OCIOSO;
        end

        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencial.sv
module tb_mult_sequencial;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ini = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [31:0] resultado;
  logic        ocupado;
  logic        pronto;

  int checks = 0;
  int passes = 0;

  mult_sequencial #(.LARGURA(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ini       (ini),
    .A         (A),
    .B         (B),
    .resultado (resultado),
    .ocupado   (ocupado),
    .pronto    (pronto)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Behavioural model: an operation occupies 17 cycles after its start edge,
  // then the arithmetic product appears with a one-cycle completion pulse.
  int unsigned m_rem;
  logic [31:0] m_res, m_prod;
  logic        m_pronto, m_ini_prev;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem      <= 0;
      m_res      <= '0;
      m_prod     <= '0;
      m_pronto   <= 1'b0;
      m_ini_prev <= 1'b0;
    end else begin
      m_ini_prev <= ini;
      m_pronto   <= 1'b0;
      if (m_rem == 0) begin
        if (ini && !m_ini_prev) begin
          m_rem  <= 17;
          m_prod <= 32'(A) * 32'(B);
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_res    <= m_prod;
          m_pronto <= 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("resultado", resultado, m_res);
      check("ocupado", 32'(ocupado), 32'(m_rem != 0));
      check("pronto", 32'(pronto), 32'(m_pronto));
    end
  end

  int   pronto_cnt = 0;
  int   ocup_rises = 0;
  logic ocup_prev  = 1'b0;
  always @(negedge clk) begin
    if (pronto) pronto_cnt++;
    if (ocupado && !ocup_prev) ocup_rises++;
    ocup_prev = ocupado;
  end

  // Raise ini for one cycle, wait (bounded) for pronto, check product and latency.
  // With imediato set, ini is raised at the current negedge instead of the next.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input bit imediato, output int lat);
    if (!imediato) @(negedge clk);
    A   = a;
    B   = b;
    ini = 1'b1;
    @(negedge clk);
    ini = 1'b0;
    lat = 1;
    while (!pronto && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("pronto_timeout", 32'(pronto), 32'd1);
    check("produto", resultado, exp);
  endtask

  int lat, p0, o0;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_resultado", resultado, 32'd0);
    check("reset_ocupado", 32'(ocupado), 32'd0);
    check("reset_pronto", 32'(pronto), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1. 3*5, pronto visible 18 negedges after ini was raised
    run_op(16'd3, 16'd5, 32'h0000_000F, 1'b0, lat);
    check("latencia_3x5", 32'(lat), 32'd18);
    repeat (3) @(negedge clk);

    // 2. Carry path and zero operand (no early exit)
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, lat);
    run_op(16'h0000, 16'h1234, 32'h0000_0000, 1'b0, lat);
    check("latencia_zero", 32'(lat), 32'd18);
    repeat (3) @(negedge clk);

    // 3. ini held high for 40 cycles: one operation only
    p0 = pronto_cnt;
    o0 = ocup_rises;
    @(negedge clk);
    A   = 16'd7;
    B   = 16'd6;
    ini = 1'b1;
    repeat (40) @(negedge clk);
    ini = 1'b0;
    repeat (5) @(negedge clk);
    check("ini_alto_pulsos", 32'(pronto_cnt - p0), 32'd1);
    check("ini_alto_ocupado", 32'(ocup_rises - o0), 32'd1);
    check("ini_alto_produto", resultado, 32'd42);

    // 4. Operand change and ini toggle during CALC are ignored
    p0 = pronto_cnt;
    @(negedge clk);
    A   = 16'd10;
    B   = 16'd10;
    ini = 1'b1;
    @(negedge clk);
    ini = 1'b0;
    repeat (4) @(negedge clk);
    A   = 16'd99;
    ini = 1'b1;
    @(negedge clk);
    ini = 1'b0;
    repeat (40) @(negedge clk);
    check("toggle_produto", resultado, 32'd100);
    check("toggle_pulsos", 32'(pronto_cnt - p0), 32'd1);

    // 5. Reset mid-operation aborts with no pronto
    p0 = pronto_cnt;
    @(negedge clk);
    A   = 16'd9;
    B   = 16'd9;
    ini = 1'b1;
    @(negedge clk);
    ini = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_resultado", resultado, 32'd0);
    check("abort_ocupado", 32'(ocupado), 32'd0);
    check("abort_pronto", 32'(pronto), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_pulsos", 32'(pronto_cnt - p0), 32'd0);
    run_op(16'd2, 16'd4, 32'd8, 1'b0, lat);

    // 6. Back-to-back: re-raise ini in the first idle cycle after completion
    repeat (2) @(negedge clk);
    run_op(16'd12, 16'd12, 32'd144, 1'b0, lat);
    run_op(16'd256, 16'd256, 32'h0001_0000, 1'b1, lat);
    check("back2back_latencia", 32'(lat), 32'd18);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
